// File: rtl/feature_mem_loader_pkg.sv
// feature_mem_loader_pkg
// Shared definitions for the feature memory write sequencer:
//   - FSM state encoding
//   - group / line address widths
package feature_mem_loader_pkg;

    localparam int GROUP_W = 8;
    localparam int LINE_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/feature_mem_loader_wrap.sv
// wrap_counter
// Up-counter that returns to zero after reaching a programmable limit.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear to zero (takes priority over inc)
//   inc       - advance by one
//   limit     - last value before wrapping (inclusive)
//   value     - current count
//   wrap      - combinational: inc is asserted while value == limit,
//               i.e. this increment returns the counter to zero
module wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    assign wrap = inc && (value == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/feature_mem_loader.sv
// feature_mem_loader
// Write sequencer in front of the scratchpad feature memory. Accepts a
// valid/ready stream of feature lines and issues one registered write per
// accepted beat, walking groups x lines in group-major order, then pulses
// done for one cycle.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - begin a fill (sampled in IDLE only)
//   cfg_groups          - groups to fill, clamped to Tn
//   cfg_lines           - lines per group, clamped to KERNEL_SIZE
//   s_valid/s_data      - upstream beat
//   s_ready             - high only while loading
//   wr_en               - write strobe (registered)
//   wr_mem_group/line   - write address (registered, zero when idle)
//   i_port              - write data (registered, zero when idle)
//   busy                - high in LOAD and DONE
//   done                - one-cycle fill-complete pulse
module feature_mem_loader
    import feature_mem_loader_pkg::*;
#(
    parameter int Tn             = 4,
    parameter int KERNEL_SIZE    = 3,
    parameter int DATA_BUS_WIDTH = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [GROUP_W-1:0]        cfg_groups,
    input  logic [LINE_W-1:0]         cfg_lines,
    input  logic                      s_valid,
    input  logic [DATA_BUS_WIDTH-1:0] s_data,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [GROUP_W-1:0]        wr_mem_group,
    output logic [LINE_W-1:0]         wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] i_port,
    output logic                      busy,
    output logic                      done
);

    localparam logic [GROUP_W-1:0] GROUP_MAX = GROUP_W'(Tn);
    localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(KERNEL_SIZE);

    state_t              state_reg;
    logic [GROUP_W-1:0]  eff_groups_reg;
    logic [LINE_W-1:0]   eff_lines_reg;
    logic [GROUP_W-1:0]  eff_groups_next;
    logic [LINE_W-1:0]   eff_lines_next;

    logic [GROUP_W-1:0]  grp_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic [GROUP_W-1:0]  grp_limit;
    logic [LINE_W-1:0]   line_limit;
    logic                grp_wrap;
    logic                line_wrap;
    logic                accept;
    logic                cnt_clr;

    assign eff_groups_next = (cfg_groups > GROUP_MAX) ? GROUP_MAX : cfg_groups;
    assign eff_lines_next  = (cfg_lines  > LINE_MAX)  ? LINE_MAX  : cfg_lines;

    // Limits are only consumed in LOAD, where both effective sizes are
    // guaranteed non-zero, so the decrement never underflows in use.
    assign grp_limit  = eff_groups_reg - GROUP_W'(1);
    assign line_limit = eff_lines_reg  - LINE_W'(1);

    // s_ready is registered and high exactly in LOAD.
    assign accept  = s_valid && s_ready;
    assign cnt_clr = (state_reg == IDLE) && start;

    wrap_counter #(.WIDTH(LINE_W)) u_line_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (accept),
        .limit (line_limit),
        .value (line_cnt),
        .wrap  (line_wrap)
    );

    // The group counter only advances when the line counter wraps; its own
    // wrap therefore marks the final beat of the fill.
    wrap_counter #(.WIDTH(GROUP_W)) u_grp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (line_wrap),
        .limit (grp_limit),
        .value (grp_cnt),
        .wrap  (grp_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            eff_groups_reg <= '0;
            eff_lines_reg  <= '0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            wr_en          <= 1'b0;
            wr_mem_group   <= '0;
            wr_mem_line    <= '0;
            i_port         <= '0;
        end else begin
            // Write port defaults to all-zero so no stale address/data lingers.
            wr_en        <= 1'b0;
            wr_mem_group <= '0;
            wr_mem_line  <= '0;
            i_port       <= '0;
            done         <= 1'b0;

            case (state_reg)
                IDLE: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        eff_groups_reg <= eff_groups_next;
                        eff_lines_reg  <= eff_lines_next;
                        busy           <= 1'b1;
                        if ((eff_groups_next == '0) || (eff_lines_next == '0)) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= LOAD;
                            s_ready   <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        wr_en        <= 1'b1;
                        wr_mem_group <= grp_cnt;
                        wr_mem_line  <= line_cnt;
                        i_port       <= s_data;
                        if (grp_wrap) begin
                            state_reg <= DONE;
                            s_ready   <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_mem_loader.sv
// tb_feature_mem_loader
// Self-checking bench: a table of fill scenarios is applied in a loop; every
// accepted beat pushes its expected write into a scoreboard queue that a
// negedge monitor pops when wr_en appears. A hand-written sequence covers the
// asynchronous reset in the middle of a fill.
module tb_feature_mem_loader;

    localparam int TN = 4;
    localparam int KS = 3;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cfg_groups;
    logic [3:0]    cfg_lines;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [7:0]    wr_mem_group;
    logic [3:0]    wr_mem_line;
    logic [DW-1:0] i_port;
    logic          busy;
    logic          done;

    int n_cmp      = 0;
    int n_bad      = 0;
    int wr_count   = 0;
    int done_count = 0;

    typedef struct {
        logic [7:0]    g;
        logic [3:0]    l;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        string      name;
        logic [7:0] cg;
        logic [3:0] cl;
        logic [7:0] vpat;
        int         plen;
        int         exp_writes;
        int         poke;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[8];

    feature_mem_loader #(
        .Tn             (TN),
        .KERNEL_SIZE    (KS),
        .DATA_BUS_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_groups   (cfg_groups),
        .cfg_lines    (cfg_lines),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_mem_group (wr_mem_group),
        .wr_mem_line  (wr_mem_line),
        .i_port       (i_port),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one line per observed write.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_count++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    $display("write g=%0d l=%0d data=%0h", wr_mem_group, wr_mem_line, i_port);
                    check("wr_addr", {52'd0, wr_mem_group, wr_mem_line}, {52'd0, e.g, e.l});
                    check("wr_data", {16'd0, i_port}, {16'd0, e.d});
                end
            end else begin
                check("idle_zero", {4'd0, wr_mem_group, wr_mem_line, i_port}, 64'd0);
            end
            if (done) done_count++;
        end
    end

    task automatic run_fill(input vec_t v);
        int eg, el, g, l, beat, cyc, w0, d0;
        bit fin;
        eg   = (int'(v.cg) > TN) ? TN : int'(v.cg);
        el   = (int'(v.cl) > KS) ? KS : int'(v.cl);
        g    = 0;
        l    = 0;
        beat = 0;
        cyc  = 0;
        fin  = 1'b0;
        w0   = wr_count;
        d0   = done_count;

        @(posedge clk); #1;
        start      = 1'b1;
        cfg_groups = v.cg;
        cfg_lines  = v.cl;
        @(posedge clk); #1;
        start      = 1'b0;
        cfg_groups = 8'd1;
        cfg_lines  = 4'd1;

        while (!fin && cyc < 300) begin
            start = 1'b0;
            if (done) begin
                fin     = 1'b1;
                s_valid = 1'b0;
                check({v.name, "_done_wr"}, {63'd0, wr_en}, {63'd0, (v.exp_writes > 0)});
                check({v.name, "_done_ready"}, {63'd0, s_ready}, 64'd0);
                check({v.name, "_done_busy"}, {63'd0, busy}, 64'd1);
                if (v.exp_writes == 0) check({v.name, "_zero_latency"}, 64'(cyc), 64'd0);
            end else begin
                if (cyc == 0) begin
                    check({v.name, "_load_ready"}, {63'd0, s_ready}, 64'd1);
                    check({v.name, "_load_busy"}, {63'd0, busy}, 64'd1);
                end
                if (cyc == v.poke) begin
                    start      = 1'b1;
                    cfg_groups = 8'd1;
                    cfg_lines  = 4'd1;
                end
                s_valid = v.vpat[cyc % v.plen];
                s_data  = {8'hA5, v.cg, 32'(beat)};
                if (s_valid && s_ready) begin
                    sb.push_back('{g: 8'(g), l: 4'(l), d: s_data});
                    beat++;
                    if (l == el - 1) begin
                        l = 0;
                        g++;
                    end else begin
                        l++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (!fin) check({v.name, "_timeout"}, 64'd1, 64'd0);

        @(posedge clk); #1;
        check({v.name, "_post_busy"}, {63'd0, busy}, 64'd0);
        check({v.name, "_post_done"}, {63'd0, done}, 64'd0);
        check({v.name, "_post_ready"}, {63'd0, s_ready}, 64'd0);
        check({v.name, "_writes"}, 64'(wr_count - w0), 64'(v.exp_writes));
        check({v.name, "_model_writes"}, 64'(beat), 64'(eg * el));
        check({v.name, "_done_count"}, 64'(done_count - d0), 64'd1);
        check({v.name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        $display("fill %s: groups=%0d lines=%0d writes=%0d", v.name, v.cg, v.cl, wr_count - w0);
    endtask

    initial begin
        int beat, guard, w0, d0;

        vecs[0] = '{"full",          8'd4, 4'd3,  8'hFF, 1, 12, -1};
        vecs[1] = '{"clamp",         8'd9, 4'd7,  8'hFF, 1, 12, -1};
        vecs[2] = '{"stall",         8'd2, 4'd2,  8'h59, 7, 4,  -1};
        vecs[3] = '{"zero_groups",   8'd0, 4'd3,  8'hFF, 1, 0,  -1};
        vecs[4] = '{"zero_lines",    8'd3, 4'd0,  8'hFF, 1, 0,  -1};
        vecs[5] = '{"ignored_start", 8'd4, 4'd3,  8'hFF, 1, 12, 3};
        vecs[6] = '{"single",        8'd1, 4'd1,  8'hFF, 1, 1,  -1};
        vecs[7] = '{"clamp_lines",   8'd2, 4'd15, 8'h0D, 4, 6,  -1};

        rst        = 1'b1;
        start      = 1'b0;
        cfg_groups = 8'd0;
        cfg_lines  = 4'd0;
        s_valid    = 1'b0;
        s_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {2'd0, wr_en, s_ready, busy, done, wr_mem_group, wr_mem_line, i_port}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", {63'd0, s_ready}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_fill(vecs[i]);
        end

        // Asynchronous reset after five beats of a 4x3 fill.
        @(posedge clk); #1;
        start      = 1'b1;
        cfg_groups = 8'd4;
        cfg_lines  = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        beat  = 0;
        guard = 0;
        while (beat < 5 && guard < 50) begin
            s_valid = 1'b1;
            s_data  = {16'hBEEF, 32'(beat)};
            if (s_ready) begin
                sb.push_back('{g: 8'(beat / 3), l: 4'(beat % 3), d: s_data});
                beat++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check("rst_seq_beats", 64'(beat), 64'd5);
        // Fifth write is on the outputs now and another beat is pending.
        rst = 1'b1;
        #1;
        check("rst_async_clear", {2'd0, wr_en, s_ready, busy, done, wr_mem_group, wr_mem_line, i_port}, 64'd0);
        sb.delete();
        w0 = wr_count;
        d0 = done_count;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("rst_no_done", 64'(done_count - d0), 64'd0);
        check("rst_no_write", 64'(wr_count - w0), 64'd0);
        check("rst_idle_ready", {63'd0, s_ready}, 64'd0);
        $display("reset mid-fill: writes after release=%0d dones=%0d", wr_count - w0, done_count - d0);

        run_fill('{"after_reset", 8'd4, 4'd3, 8'hFF, 1, 12, -1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
